// File: rtl/apb_req_arbiter_if.sv
// Requester-side handshake and APB bus signals of apb_req_arbiter.
// master: arbiter view; slave: view of the requesters/APB slave around it.
interface apb_req_arbiter_if #(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned DAT_W = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_write;
    logic [2*ADR_W-1:0] req_addr;
    logic [2*DAT_W-1:0] req_wdata;
    logic [1:0]         req_ready;
    logic [1:0]         rsp_valid;
    logic [DAT_W-1:0]   rsp_rdata;
    logic               rsp_err;
    logic [ADR_W-1:0]   PADDR;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [DAT_W-1:0]   PWDATA;
    logic               PREADY;
    logic [DAT_W-1:0]   PRDATA;
    logic               PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-port round-robin arbiter in front of a single APB master, with an
// optional PREADY timeout that aborts a stalled ACCESS phase.
module apb_req_arbiter #(
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_req_arbiter_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [ADR_W-1:0]   addr_q, addr_d;
    logic               write_q, write_d;
    logic [DAT_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               winner;
    logic [1:0]         req_ready;
    logic               psel;
    logic               penable;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = '0;
        psel         = 1'b0;
        penable      = 1'b0;
        // The port that did not win last time gets priority when it requests.
        winner       = bus.req_valid[~last_grant_q] ? ~last_grant_q : last_grant_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready[winner] = 1'b1;
                    last_grant_d      = winner;
                    addr_d            = winner ? bus.req_addr[2*ADR_W-1:ADR_W]  : bus.req_addr[ADR_W-1:0];
                    wdata_d           = winner ? bus.req_wdata[2*DAT_W-1:DAT_W] : bus.req_wdata[DAT_W-1:0];
                    write_d           = bus.req_write[winner];
                    cnt_d             = '0;
                    state_d           = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (bus.PREADY) begin
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = write_q ? '0 : bus.PRDATA;
                    rsp_err_d                 = bus.PSLVERR;
                    state_d                   = IDLE;
                end else if (TIMEOUT != 0) begin
                    if (32'(cnt_q) + 32'd1 == TIMEOUT) begin
                        rsp_valid_d[last_grant_q] = 1'b1;
                        rsp_rdata_d               = '0;
                        rsp_err_d                 = 1'b1;
                        state_d                   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State is IDLE during reset, so the accept strobe must be gated explicitly.
    assign bus.req_ready = PRESETn ? req_ready : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = addr_q;
    assign bus.PWRITE    = write_q;
    assign bus.PWDATA    = wdata_q;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (TIMEOUT=4) with hand-computed expectations.
module tb_apb_req_arbiter;
    logic PCLK;
    logic PRESETn;
    int   n_chk;
    int   n_bad;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;

    apb_req_arbiter_if #(.ADR_W(32), .DAT_W(32)) bus ();

    apb_req_arbiter #(.ADR_W(32), .DAT_W(32), .TIMEOUT(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        n_chk         = 0;
        n_bad         = 0;
        PRESETn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // Reset state, including req_ready held low with requests present
        @(negedge PCLK);
        check("rst_psel",    bus.PSEL,      1'b0);
        check("rst_penable", bus.PENABLE,   1'b0);
        check("rst_pwrite",  bus.PWRITE,    1'b0);
        check("rst_paddr",   bus.PADDR,     32'h0);
        check("rst_pwdata",  bus.PWDATA,    32'h0);
        check("rst_rsp_v",   bus.rsp_valid, 2'b00);
        check("rst_rdata",   bus.rsp_rdata, 32'h0);
        check("rst_err",     bus.rsp_err,   1'b0);
        bus.req_valid = 2'b11;
        #1;
        check("rst_ready",   bus.req_ready, 2'b00);
        bus.req_valid = '0;
        next_cyc();
        PRESETn = 1'b1;

        // Port 0 write, zero-wait slave
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr  = {32'h0, 32'h0000_0004};
        bus.req_wdata = {32'h0, 32'h1234_5678};
        bus.PREADY    = 1'b1;
        @(negedge PCLK);
        check("w_ready_T",   bus.req_ready, 2'b01);
        check("w_psel_T",    bus.PSEL,      1'b0);
        next_cyc();
        bus.req_valid = '0;
        @(negedge PCLK);
        check("w_psel_T1",   bus.PSEL,      1'b1);
        check("w_pen_T1",    bus.PENABLE,   1'b0);
        check("w_paddr",     bus.PADDR,     32'h0000_0004);
        check("w_pwrite",    bus.PWRITE,    1'b1);
        check("w_pwdata",    bus.PWDATA,    32'h1234_5678);
        next_cyc();
        @(negedge PCLK);
        check("w_psel_T2",   bus.PSEL,      1'b1);
        check("w_pen_T2",    bus.PENABLE,   1'b1);
        check("w_rspv_T2",   bus.rsp_valid, 2'b00);
        next_cyc();
        @(negedge PCLK);
        check("w_rspv_T3",   bus.rsp_valid, 2'b01);
        check("w_err_T3",    bus.rsp_err,   1'b0);
        check("w_rdata_T3",  bus.rsp_rdata, 32'h0);
        check("w_psel_T3",   bus.PSEL,      1'b0);
        next_cyc();

        // Reset, then both ports request continuously: grants 0,1,0,1 every 3 cycles
        PRESETn = 1'b0;
        next_cyc();
        PRESETn = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = {32'h0000_0200, 32'h0000_0100};
        bus.PRDATA    = 32'hA5A5_0000;
        bus.PREADY    = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 12) bus.req_valid = '0;
            @(negedge PCLK);
            exp_rdy = (c % 3 == 0 && c < 12) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp = (c % 3 == 0 && c > 0) ? ((((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check("rr_ready", bus.req_ready, exp_rdy);
            check("rr_rspv",  bus.rsp_valid, exp_rsp);
            if (c % 3 == 1)
                check("rr_paddr", bus.PADDR, ((c / 3) % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            if (c % 3 == 0 && c > 0)
                check("rr_rdata", bus.rsp_rdata, 32'hA5A5_0000);
            next_cyc();
        end

        // Port 1 read with 3 wait states
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr  = {32'h0000_0300, 32'h0};
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'h0;
        @(negedge PCLK);
        check("ws_ready", bus.req_ready, 2'b10);
        next_cyc();
        bus.req_valid = '0;
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("ws_pen",   bus.PENABLE,   1'b1);
            check("ws_paddr", bus.PADDR,     32'h0000_0300);
            check("ws_rspv",  bus.rsp_valid, 2'b00);
            next_cyc();
        end
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'hDEAD_BEEF;
        @(negedge PCLK);
        check("ws_paddr4", bus.PADDR, 32'h0000_0300);
        next_cyc();
        @(negedge PCLK);
        check("ws_rspv_done", bus.rsp_valid, 2'b10);
        check("ws_rdata",     bus.rsp_rdata, 32'hDEAD_BEEF);
        check("ws_err",       bus.rsp_err,   1'b0);
        next_cyc();

        // Port 0 read with PSLVERR, port 1 accepted in the completion cycle
        bus.req_valid = 2'b01;
        bus.req_write = 2'b00;
        bus.req_addr  = {32'h0000_0500, 32'h0000_0400};
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b1;
        bus.PRDATA    = 32'hCAFE_0001;
        @(negedge PCLK);
        check("se_ready0", bus.req_ready, 2'b01);
        next_cyc();
        bus.req_valid = '0;
        next_cyc();
        next_cyc();
        bus.req_valid = 2'b10;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = 32'h1111_2222;
        @(negedge PCLK);
        check("se_rspv",   bus.rsp_valid, 2'b01);
        check("se_err",    bus.rsp_err,   1'b1);
        check("se_rdata",  bus.rsp_rdata, 32'hCAFE_0001);
        check("se_ready1", bus.req_ready, 2'b10);
        next_cyc();
        bus.req_valid = '0;
        @(negedge PCLK);
        check("se_rspv_off", bus.rsp_valid, 2'b00);
        check("se_err_hold", bus.rsp_err,   1'b1);
        check("se_paddr1",   bus.PADDR,     32'h0000_0500);
        next_cyc();
        next_cyc();
        @(negedge PCLK);
        check("se_rspv1",  bus.rsp_valid, 2'b10);
        check("se_err1",   bus.rsp_err,   1'b0);
        check("se_rdata1", bus.rsp_rdata, 32'h1111_2222);
        next_cyc();

        // Timeout: PREADY stuck low for 4 ACCESS cycles
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr  = {32'h0, 32'h0000_0600};
        bus.req_wdata = {32'h0, 32'h0000_0077};
        bus.PREADY    = 1'b0;
        @(negedge PCLK);
        check("to_ready", bus.req_ready, 2'b01);
        next_cyc();
        bus.req_valid = '0;
        @(negedge PCLK);
        check("to_setup", {bus.PSEL, bus.PENABLE}, 2'b10);
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("to_access", {bus.PSEL, bus.PENABLE}, 2'b11);
            check("to_rspv",   bus.rsp_valid, 2'b00);
            next_cyc();
        end
        @(negedge PCLK);
        check("to_psel",  {bus.PSEL, bus.PENABLE}, 2'b00);
        check("to_rspv1", bus.rsp_valid, 2'b01);
        check("to_err",   bus.rsp_err,   1'b1);
        check("to_rdata", bus.rsp_rdata, 32'h0);
        next_cyc();
        @(negedge PCLK);
        check("to_rspv_off", bus.rsp_valid, 2'b00);
        next_cyc();

        // Reset during ACCESS: immediate bus release, no response, port 0 wins afterwards
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = {32'h0000_0800, 32'h0000_0700};
        @(negedge PCLK);
        check("ra_ready", bus.req_ready, 2'b10);
        next_cyc();
        bus.req_valid = '0;
        next_cyc();
        @(negedge PCLK);
        check("ra_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        bus.PREADY    = 1'b1;
        bus.req_valid = 2'b11;
        #2;
        PRESETn = 1'b0;
        #1;
        check("ra_bus_off", {bus.PSEL, bus.PENABLE}, 2'b00);
        check("ra_ready_r", bus.req_ready, 2'b00);
        next_cyc();
        check("ra_rspv_r",  bus.rsp_valid, 2'b00);
        #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("ra_grant0",  bus.req_ready, 2'b01);
        check("ra_rspv_p",  bus.rsp_valid, 2'b00);
        next_cyc();
        bus.req_valid = '0;
        next_cyc();
        next_cyc();
        @(negedge PCLK);
        check("ra_done0",   bus.rsp_valid, 2'b01);
        next_cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter ADR_W, default 32, APB address width.
REQ-002 SHALL have parameter DAT_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max consecutive ACCESS cycles with PREADY low before abort (0 = disabled).
REQ-004 SHALL use reset PRESETn, asynchronous, active-low, and clock PCLK.
REQ-005 SHALL have ports:
  PCLK  in  1  clock
  PRESETn  in  1  async active-low reset
  req_valid  in  2  per-requester transfer request
  req_write  in  2  per-requester direction (1 = write)
  req_addr  in  2*ADR_W  per-requester address; port n at [n*ADR_W +: ADR_W]
  req_wdata  in  2*DAT_W  per-requester write data; port n at [n*DAT_W +: DAT_W]
  req_ready  out  2  one-hot accept strobe
  rsp_valid  out  2  one-hot completion strobe
  rsp_rdata  out  DAT_W  read data for completing port
  rsp_err  out  1  slave error or timeout for completing port
  PADDR  out  ADR_W  APB address
  PSEL  out  1  APB select
  PENABLE  out  1  APB enable
  PWRITE  out  1  APB direction
  PWDATA  out  DAT_W  APB write data
  PREADY  in  1  APB ready
  PRDATA  in  DAT_W  APB read data
  PSLVERR  in  1  APB slave error

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS; exactly one active.
REQ-007 SHALL, in IDLE with any req_valid high, select a winner, assert req_ready[winner] combinationally in that cycle, capture winner's addr/write/wdata into registers, and go to SETUP.
REQ-008 SHALL arbitrate round-robin: winner is the requesting port other than last_grant if it requests, else last_grant; last_grant updates on every accept.
REQ-009 SHALL have req_ready low for both ports outside IDLE and for non-requesting ports.
REQ-010 SHALL, in SETUP, drive PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from captured registers, and go to ACCESS unconditionally.
REQ-011 SHALL, in ACCESS, drive PSEL=1, PENABLE=1 with PADDR/PWRITE/PWDATA held stable.
REQ-012 SHALL, in ACCESS with PREADY=1, register PRDATA (reads) or 0 (writes) into rsp_rdata, PSLVERR into rsp_err, pulse rsp_valid[granted] for exactly one cycle following that edge, and go to IDLE.
REQ-013 SHALL count consecutive ACCESS cycles with PREADY=0 in a counter cleared on entry to SETUP; when TIMEOUT!=0 and count reaches TIMEOUT, drop PSEL/PENABLE, set rsp_err=1, rsp_rdata=0, pulse rsp_valid[granted], go to IDLE.
REQ-014 SHALL drive PSEL=0, PENABLE=0 in IDLE; PADDR/PWRITE/PWDATA hold last captured values.
REQ-015 SHALL allow a new accept in the IDLE cycle where rsp_valid is high (back-to-back); minimum spacing between accepts is 3 cycles.
REQ-016 SHALL hold rsp_rdata and rsp_err stable until the next completion.
REQ-017 SHALL ignore req_valid changes while not in IDLE; a requester dropping req_valid after acceptance does not cancel the transfer.

Reset
REQ-018 SHALL, on PRESETn low, immediately force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout count=0, last_grant=1 (port 0 wins first).
REQ-019 SHALL abandon any in-flight transfer on reset without issuing rsp_valid.

Verification
REQ-020 Port 0 write addr 0x0000_0004 data 0x1234_5678, PREADY=1 -> req_ready[0] cycle T, PSEL T+1, PENABLE T+2, rsp_valid[0] T+3, rsp_err=0.
REQ-021 Both ports request continuously after reset -> grants 0,1,0,1 with accepts 3 cycles apart.
REQ-022 Port 1 read, slave holds PREADY=0 for 3 ACCESS cycles then PRDATA=0xDEAD_BEEF, PREADY=1 -> rsp_valid[1] with rsp_rdata=0xDEAD_BEEF, PADDR stable throughout.
REQ-023 Read with PSLVERR=1 at PREADY=1 -> rsp_err=1, rsp_valid one cycle, next request accepted same cycle.
REQ-024 TIMEOUT=4, PREADY stuck 0 -> after 4 ACCESS cycles PSEL=0, rsp_valid pulsed, rsp_err=1, rsp_rdata=0.
REQ-025 PRESETn low during ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid; first post-reset dual request granted to port 0.
